// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. Each cycle the
//   arbiter grants at most one valid request, alternating priority when both
//   requesters are valid. It drives the ALU with the winner's operands and
//   captures the result, the requester id and the tag in a one-entry response
//   register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_operand_a/b, alu_op   request payload
//   reqN_tag                   opaque tag returned with the result
//   alu_operand_a/b, alu_op    drive to the shared ALU (all 0 when idle)
//   alu_result                 combinational result from the shared ALU
//   rsp_valid/ready            response handshake
//   rsp_result, rsp_id, rsp_tag  captured result, requester index, tag
//   busy_cycles                saturating count of grant cycles
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_operand_a,
  input  logic [DATA_W-1:0] req0_operand_b,
  input  logic [3:0]        req0_alu_op,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_operand_a,
  input  logic [DATA_W-1:0] req1_operand_b,
  input  logic [3:0]        req1_alu_op,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [15:0]       busy_cycles
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        op;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t [1:0] req;
  req_t       sel;
  logic [1:0] vld;
  logic [1:0] gnt;
  logic       can_accept;
  logic       any_gnt;
  logic       prio;       // 0: requester 0 wins a tie, 1: requester 1 wins

  assign req[0] = {req0_operand_a, req0_operand_b, req0_alu_op, req0_tag};
  assign req[1] = {req1_operand_a, req1_operand_b, req1_alu_op, req1_tag};
  assign vld    = {req1_valid, req0_valid};

  // rst_n is folded in so that no ready can appear while reset is held,
  // even though rsp_valid is already cleared by then.
  assign can_accept = rst_n && (!rsp_valid || rsp_ready);

  assign gnt[0]  = can_accept && vld[0] && (!vld[1] || !prio);
  assign gnt[1]  = can_accept && vld[1] && (!vld[0] ||  prio);
  assign any_gnt = |gnt;

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    sel = '0;
    if (gnt[0])      sel = req[0];
    else if (gnt[1]) sel = req[1];
  end

  assign alu_operand_a = sel.a;
  assign alu_operand_b = sel.b;
  assign alu_op        = sel.op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_id      <= 1'b0;
      rsp_tag     <= '0;
      busy_cycles <= '0;
      prio        <= 1'b0;
    end else if (any_gnt) begin
      // A grant implies can_accept, so reloading here also covers the
      // drain-and-refill case at full throughput.
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_id     <= gnt[1];
      rsp_tag    <= sel.tag;
      prio       <= gnt[0];
      if (busy_cycles != 16'hFFFF) busy_cycles <= busy_cycles + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   reference model (response register contents, tie-break owner, busy count)
//   and a behavioural ALU that stands in for the shared ALU.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2,
                         OP_SRL = 4'd3, OP_SRA = 4'd4, OP_XOR = 4'd5,
                         OP_OR  = 4'd6, OP_AND = 4'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_operand_a = '0, req0_operand_b = '0;
  logic [31:0] req1_operand_a = '0, req1_operand_b = '0;
  logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
  logic [3:0]  req0_tag = '0, req1_tag = '0;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [15:0] busy_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b),
    .req0_alu_op(req0_alu_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b),
    .req1_alu_op(req1_alu_op), .req1_tag(req1_tag),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy_cycles(busy_cycles)
  );

  // Behavioural stand-in for the shared ALU; undefined ops yield an
  // arbitrary but deterministic value that the arbiter must pass through.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      default: return {a[15:0], b[15:0]} ^ {28'h5A5A5A5, op};
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_operand_a, alu_operand_b, alu_op);

  // Reference model: who wins this cycle (-1 = nobody).
  bit          m_vld = 1'b0;
  logic [31:0] m_res = '0;
  bit          m_id = 1'b0;
  logic [3:0]  m_tag = '0;
  int          m_busy = 0;
  int          m_favour = 0;   // requester that wins a tie
  int          eg;

  function automatic int exp_grant(input bit rn, input bit v0, input bit v1,
                                   input bit rr, input bit held, input int fav);
    if (!rn) return -1;
    if (held && !rr) return -1;
    if (v0 && v1) return fav;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  assign eg = exp_grant(rst_n, req0_valid, req1_valid, rsp_ready, m_vld, m_favour);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0; m_res <= '0; m_id <= 1'b0; m_tag <= '0;
      m_busy <= 0; m_favour <= 0;
    end else if (eg == 0) begin
      m_vld <= 1'b1; m_id <= 1'b0; m_tag <= req0_tag; m_favour <= 1;
      m_res <= alu_f(req0_operand_a, req0_operand_b, req0_alu_op);
      m_busy <= (m_busy < 65535) ? m_busy + 1 : 65535;
    end else if (eg == 1) begin
      m_vld <= 1'b1; m_id <= 1'b1; m_tag <= req1_tag; m_favour <= 0;
      m_res <= alu_f(req1_operand_a, req1_operand_b, req1_alu_op);
      m_busy <= (m_busy < 65535) ? m_busy + 1 : 65535;
    end else if (rsp_ready) begin
      m_vld <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input bit v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [3:0] tag);
    req0_valid = v; req0_operand_a = a; req0_operand_b = b;
    req0_alu_op = op; req0_tag = tag;
  endtask

  task automatic set_req1(input bit v, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [3:0] tag);
    req1_valid = v; req1_operand_a = a; req1_operand_b = b;
    req1_alu_op = op; req1_tag = tag;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    rsp_ready  = 1'b1;
    repeat (2) tick();
    n_tests++;
    if ({rsp_valid, rsp_result, rsp_id, rsp_tag, busy_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%h id=%b t=%h b=%h want all 0",
               rsp_valid, rsp_result, rsp_id, rsp_tag, busy_cycles);
    end
    n_tests++;
    if (req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0", req0_ready);
    end
    req0_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req0(1'b1, 32'd5, 32'd7, OP_ADD, 4'd3);
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || alu_op !== OP_ADD ||
        alu_operand_a !== 32'd5 || alu_operand_b !== 32'd7) begin
      n_fail++;
      $display("FAIL single_grant: got rdy=%b%b op=%h a=%h b=%h want rdy=01 op=0 a=5 b=7",
               req1_ready, req0_ready, alu_op, alu_operand_a, alu_operand_b);
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0 ||
        rsp_tag !== 4'd3 || busy_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b r=%h id=%b t=%h b=%0d want 1 0000000c 0 3 1",
               rsp_valid, rsp_result, rsp_id, rsp_tag, busy_cycles);
    end
    #1;
    n_tests++;
    if ({alu_operand_a, alu_operand_b, alu_op} !== '0) begin
      n_fail++;
      $display("FAIL idle_alu_drive: got a=%h b=%h op=%h want 0", alu_operand_a,
               alu_operand_b, alu_op);
    end
  endtask

  // The previous grant went to requester 0, so requester 1 leads here.
  task automatic test_contention();
    set_req0(1'b1, 32'd10, 32'd3, OP_SUB, 4'd1);
    set_req1(1'b1, 32'hF0, 32'h0F, OP_XOR, 4'd2);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = (k % 2 == 0);
      #1;
      n_tests++;
      if (req1_ready !== w || req0_ready !== !w) begin
        n_fail++;
        $display("FAIL contention_ready[%0d]: got rdy=%b%b want winner %0d", k,
                 req1_ready, req0_ready, w);
      end
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== w ||
          rsp_result !== (w ? 32'hFF : 32'd7)) begin
        n_fail++;
        $display("FAIL contention_rsp[%0d]: got v=%b id=%b r=%h want id=%0d r=%h", k,
                 rsp_valid, rsp_id, rsp_result, w, (w ? 32'hFF : 32'd7));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    set_req0(1'b1, 32'd2, 32'd3, OP_ADD, 4'd5);
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    set_req1(1'b1, 32'd1, 32'd4, OP_SLL, 4'd6);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b%b want 00", k, req1_ready, req0_ready);
      end
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd5 || rsp_id !== 1'b0 ||
          rsp_tag !== 4'd5) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b r=%h id=%b t=%h want 1 5 0 5", k,
                 rsp_valid, rsp_result, rsp_id, rsp_tag);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_grant: got req1_ready=%b want 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd16 || rsp_id !== 1'b1 ||
        rsp_tag !== 4'd6) begin
      n_fail++;
      $display("FAIL drain_rsp: got v=%b r=%h id=%b t=%h want 1 10 1 6",
               rsp_valid, rsp_result, rsp_id, rsp_tag);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    set_req1(1'b1, 32'h80000000, 32'd4, OP_SRA, 4'd7);
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready0: got %b want 1", req1_ready);
    end
    tick();
    set_req1(1'b1, 32'h80000000, 32'd4, OP_SRL, 4'd8);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'hF8000000 || rsp_tag !== 4'd7) begin
      n_fail++;
      $display("FAIL b2b_sra: got v=%b r=%h t=%h want 1 f8000000 7", rsp_valid,
               rsp_result, rsp_tag);
    end
    #1;
    n_tests++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready1: got %b want 1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'h08000000 || rsp_tag !== 4'd8) begin
      n_fail++;
      $display("FAIL b2b_srl: got v=%b r=%h t=%h want 1 08000000 8", rsp_valid,
               rsp_result, rsp_tag);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    set_req0(1'b1, 32'hFFFF, 32'h0F0F, OP_AND, 4'd9);
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy_cycles !== 16'd0 || rsp_result !== '0 ||
        rsp_tag !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b b=%0d r=%h t=%h want all 0", rsp_valid,
               busy_cycles, rsp_result, rsp_tag);
    end
    set_req0(1'b1, 32'd10, 32'd3, OP_SUB, 4'd1);
    set_req1(1'b1, 32'hF0, 32'h0F, OP_XOR, 4'd2);
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_in_reset: got %b%b want 00", req1_ready, req0_ready);
    end
    #2 rst_n = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_prio: got %b%b want 01", req1_ready, req0_ready);
    end
    tick();
    #1;
    n_tests++;
    if (rsp_id !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_alt: got id=%b req1_ready=%b want 0 1", rsp_id, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      int g;
      if (!req0_valid && ($urandom % 2 == 0))
        set_req0(1'b1, $urandom, $urandom, 4'($urandom_range(0, 9)), 4'($urandom));
      if (!req1_valid && ($urandom % 2 == 0))
        set_req1(1'b1, $urandom, $urandom, 4'($urandom_range(0, 9)), 4'($urandom));
      rsp_ready = ($urandom % 4 != 0);
      #1;
      g = eg;
      n_tests++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got rdy=%b%b want winner %0d", k, req1_ready,
                 req0_ready, g);
      end
      tick();
      if (g == 0) req0_valid = 1'b0;
      if (g == 1) req1_valid = 1'b0;
      n_tests++;
      if (rsp_valid !== m_vld || busy_cycles !== m_busy[15:0] ||
          (m_vld && (rsp_result !== m_res || rsp_id !== m_id || rsp_tag !== m_tag))) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got v=%b r=%h id=%b t=%h b=%0d want v=%b r=%h id=%b t=%h b=%0d",
                 k, rsp_valid, rsp_result, rsp_id, rsp_tag, busy_cycles, m_vld, m_res,
                 m_id, m_tag, m_busy);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    set_req0(1'b1, 32'd1, 32'd1, OP_ADD, 4'd0);
    rsp_ready = 1'b1;
    repeat (65536) tick();
    n_tests++;
    if (busy_cycles !== 16'hFFFF) begin
      n_fail++; $display("FAIL busy_sat: got %h want ffff", busy_cycles);
    end
    repeat (4) tick();
    n_tests++;
    if (busy_cycles !== 16'hFFFF || rsp_valid !== 1'b1 || rsp_result !== 32'd2) begin
      n_fail++;
      $display("FAIL busy_hold: got b=%h v=%b r=%h want ffff 1 2", busy_cycles,
               rsp_valid, rsp_result);
    end
    req0_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
